// File: rtl/lynx_tape_pkg.sv
// rtl/lynx_tape_pkg.sv - shared types and defaults for the Lynx tape player
// Provides the player state enum, default timing constants, the counter
// width and the half-period reload helper used by the cell generator.
package lynx_tape_pkg;

    localparam int CNT_W = 16;

    localparam int unsigned DEF_ZERO_HALF   = 1000;
    localparam int unsigned DEF_ONE_HALF    = 2000;
    localparam int unsigned DEF_LEADER_BITS = 768;
    localparam int unsigned DEF_TRAIL_TICKS = 8000;
    localparam logic [7:0]  DEF_SYNC_BYTE   = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEADER,
        ST_SYNC,
        ST_DATA,
        ST_STALL,
        ST_TRAIL,
        ST_DONE
    } state_t;

    // Half-period counters count down from H-1 to 0.
    function automatic logic [CNT_W-1:0] half_reload(
        input logic             b,
        input logic [CNT_W-1:0] zero_half,
        input logic [CNT_W-1:0] one_half
    );
        return (b ? one_half : zero_half) - 1'b1;
    endfunction

endpackage

// File: rtl/lynx_tape_cell.sv
// rtl/lynx_tape_cell.sv - one bit cell: ear high for H ticks, then low for H ticks
// Ports: clock/reset (sync, active-high), ce tick enable, run (motor gate),
// clear (abort), start + cell_bit (begin a new cell, shows its first high
// tick on the next cycle), zero_half/one_half half-periods;
// ear level and cell_end (asserted during the cell's last low tick).
module lynx_tape_cell
    import lynx_tape_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             ce,
    input  logic             run,
    input  logic             clear,
    input  logic             start,
    input  logic             cell_bit,
    input  logic [CNT_W-1:0] zero_half,
    input  logic [CNT_W-1:0] one_half,
    output logic             ear,
    output logic             cell_end
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ear_q, ear_d;
    logic             active_q, active_d;
    logic             bit_q, bit_d;
    logic             tick;

    assign tick     = ce && run && active_q;
    assign cell_end = tick && !ear_q && (cnt_q == '0);
    assign ear      = ear_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q    <= '0;
            ear_q    <= 1'b0;
            active_q <= 1'b0;
            bit_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            ear_q    <= ear_d;
            active_q <= active_d;
            bit_q    <= bit_d;
        end
    end

    // start has priority over tick so a new cell can begin on the same edge
    // the previous one ends, leaving no gap between cells.
    always_comb begin
        cnt_d    = cnt_q;
        ear_d    = ear_q;
        active_d = active_q;
        bit_d    = bit_q;
        if (clear) begin
            cnt_d    = '0;
            ear_d    = 1'b0;
            active_d = 1'b0;
            bit_d    = 1'b0;
        end else if (start) begin
            bit_d    = cell_bit;
            ear_d    = 1'b1;
            active_d = 1'b1;
            cnt_d    = half_reload(cell_bit, zero_half, one_half);
        end else if (tick) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else if (ear_q) begin
                ear_d = 1'b0;
                cnt_d = half_reload(bit_q, zero_half, one_half);
            end else begin
                active_d = 1'b0;
            end
        end
    end

endmodule

// File: rtl/lynx_tape_player.sv
// rtl/lynx_tape_player.sv - tape byte stream to Lynx cassette ear waveform
// Ports: clock/reset (sync, active-high), ce tick enable, play/stop pulses,
// motor gate, byte_valid/byte_data/byte_last/byte_ready byte source
// handshake; ear waveform, busy, sticky underrun and done pulse.
module lynx_tape_player
    import lynx_tape_pkg::*;
#(
    parameter int unsigned ZERO_HALF   = DEF_ZERO_HALF,
    parameter int unsigned ONE_HALF    = DEF_ONE_HALF,
    parameter int unsigned LEADER_BITS = DEF_LEADER_BITS,
    parameter logic [7:0]  SYNC_BYTE   = DEF_SYNC_BYTE,
    parameter int unsigned TRAIL_TICKS = DEF_TRAIL_TICKS,
    parameter bit          MOTOR_GATE  = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic       play,
    input  logic       stop,
    input  logic       motor,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    input  logic       byte_last,
    output logic       byte_ready,
    output logic       ear,
    output logic       busy,
    output logic       underrun,
    output logic       done
);

    localparam logic [CNT_W-1:0] ZH         = CNT_W'(ZERO_HALF);
    localparam logic [CNT_W-1:0] OH         = CNT_W'(ONE_HALF);
    localparam logic [CNT_W-1:0] LEAD_LAST  = CNT_W'(LEADER_BITS - 1);
    localparam logic [CNT_W-1:0] TRAIL_LAST = CNT_W'(TRAIL_TICKS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] lead_q, lead_d;
    logic [CNT_W-1:0] trail_q, trail_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       idx_q, idx_d;
    logic             last_q, last_d;
    logic             fetch_q, fetch_d;
    logic             underrun_q, underrun_d;
    logic             done_q, done_d;

    logic run, fetch_win, cell_start, cell_bit, cell_end;

    assign run = motor || !MOTOR_GATE;

    lynx_tape_cell u_cell (
        .clock     (clock),
        .reset     (reset),
        .ce        (ce),
        .run       (run),
        .clear     (stop),
        .start     (cell_start),
        .cell_bit  (cell_bit),
        .zero_half (ZH),
        .one_half  (OH),
        .ear       (ear),
        .cell_end  (cell_end)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            lead_q     <= '0;
            trail_q    <= '0;
            shift_q    <= '0;
            idx_q      <= '0;
            last_q     <= 1'b0;
            fetch_q    <= 1'b0;
            underrun_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lead_q     <= lead_d;
            trail_q    <= trail_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            fetch_q    <= fetch_d;
            underrun_q <= underrun_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lead_d     = lead_q;
        trail_d    = trail_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        last_d     = last_q;
        fetch_d    = fetch_q;
        underrun_d = underrun_q;
        done_d     = 1'b0;
        cell_start = 1'b0;
        cell_bit   = 1'b0;
        if (stop) begin
            state_d = ST_IDLE;
            fetch_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (play) begin
                        state_d    = ST_LEADER;
                        lead_d     = '0;
                        underrun_d = 1'b0;
                        cell_start = 1'b1;
                    end
                end
                ST_LEADER: begin
                    if (cell_end) begin
                        cell_start = 1'b1;
                        if (lead_q == LEAD_LAST) begin
                            state_d  = ST_SYNC;
                            shift_d  = SYNC_BYTE;
                            idx_d    = 3'd7;
                            cell_bit = SYNC_BYTE[7];
                        end else begin
                            lead_d = lead_q + 1'b1;
                        end
                    end
                end
                ST_SYNC, ST_DATA: begin
                    // fetch_q marks the single boundary cycle between bytes.
                    if (fetch_q) begin
                        if (byte_ready) begin
                            shift_d    = byte_data;
                            last_d     = byte_last;
                            idx_d      = 3'd7;
                            fetch_d    = 1'b0;
                            cell_start = 1'b1;
                            cell_bit   = byte_data[7];
                        end else if (run) begin
                            state_d    = ST_STALL;
                            underrun_d = 1'b1;
                            fetch_d    = 1'b0;
                        end
                    end else if (cell_end) begin
                        if (idx_q != 3'd0) begin
                            shift_d    = {shift_q[6:0], 1'b0};
                            idx_d      = idx_q - 1'b1;
                            cell_start = 1'b1;
                            cell_bit   = shift_q[6];
                        end else if (state_q == ST_DATA && last_q) begin
                            state_d = ST_TRAIL;
                            trail_d = '0;
                        end else begin
                            state_d = ST_DATA;
                            fetch_d = 1'b1;
                        end
                    end
                end
                ST_STALL: begin
                    if (byte_ready) begin
                        state_d    = ST_DATA;
                        shift_d    = byte_data;
                        last_d     = byte_last;
                        idx_d      = 3'd7;
                        cell_start = 1'b1;
                        cell_bit   = byte_data[7];
                    end
                end
                ST_TRAIL: begin
                    if (ce && run) begin
                        if (trail_q == TRAIL_LAST) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            trail_d = trail_q + 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        fetch_win  = ((state_q == ST_DATA) && fetch_q) || (state_q == ST_STALL);
        byte_ready = fetch_win && byte_valid && run && !stop;
        busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    end

    assign underrun = underrun_q;
    assign done     = done_q;

endmodule

// File: tb/tb_lynx_tape_player.sv
// tb/tb_lynx_tape_player.sv - self-checking bench for lynx_tape_player
module tb_lynx_tape_player;

    localparam int ZH = 2, OH = 4, LB = 3, TT = 5, GUARD = 3000;

    logic clock = 1'b0;
    logic reset, ce, play, stop, motor, byte_valid, byte_last;
    logic [7:0] byte_data;
    logic byte_ready, ear, busy, underrun, done;

    int errors = 0, checks = 0;
    bit chk_en, ce_rand;

    always #5 clock = ~clock;

    lynx_tape_player #(
        .ZERO_HALF(ZH), .ONE_HALF(OH), .LEADER_BITS(LB),
        .SYNC_BYTE(8'hA5), .TRAIL_TICKS(TT), .MOTOR_GATE(1'b1)
    ) dut (
        .clock(clock), .reset(reset), .ce(ce), .play(play), .stop(stop),
        .motor(motor), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_last(byte_last), .byte_ready(byte_ready), .ear(ear),
        .busy(busy), .underrun(underrun), .done(done)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the tape is a queue of ear levels, one per tick.
    typedef enum {M_IDLE, M_PLAY, M_FETCH, M_TRAIL, M_DONE} mmode_t;
    mmode_t m_mode;
    bit     m_q[$];
    bit     m_ear, m_last, m_underrun, m_done;
    int     m_trail;

    function automatic void push_cell(input bit b);
        int h;
        h = b ? OH : ZH;
        repeat (h) m_q.push_back(1'b1);
        repeat (h) m_q.push_back(1'b0);
    endfunction

    function automatic void push_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) push_cell(v[i]);
    endfunction

    function automatic void model_reset();
        m_mode = M_IDLE; m_q.delete(); m_ear = 0; m_last = 0;
        m_underrun = 0; m_done = 0; m_trail = 0;
    endfunction

    function automatic bit m_busy();
        return (m_mode == M_PLAY) || (m_mode == M_FETCH) || (m_mode == M_TRAIL);
    endfunction

    function automatic bit m_ready();
        return (m_mode == M_FETCH) && byte_valid && motor && !stop;
    endfunction

    function automatic void model_edge();
        bit adv;
        adv = ce && motor;
        m_done = 0;
        if (stop) begin
            m_mode = M_IDLE; m_q.delete(); m_ear = 0;
            return;
        end
        case (m_mode)
            M_IDLE, M_DONE: if (play) begin
                m_q.delete();
                for (int i = 0; i < LB; i++) push_cell(1'b0);
                push_byte(8'hA5);
                m_last = 0; m_underrun = 0;
                m_ear = m_q.pop_front();
                m_mode = M_PLAY;
            end
            M_PLAY: if (adv) begin
                if (m_q.size() > 0) m_ear = m_q.pop_front();
                else begin
                    m_ear = 0;
                    if (m_last) begin m_mode = M_TRAIL; m_trail = TT; end
                    else m_mode = M_FETCH;
                end
            end
            M_FETCH: if (motor) begin
                if (byte_valid) begin
                    push_byte(byte_data); m_last = byte_last;
                    m_ear = m_q.pop_front(); m_mode = M_PLAY;
                end else m_underrun = 1;
            end
            M_TRAIL: if (adv) begin
                m_trail--;
                if (m_trail == 0) begin m_mode = M_DONE; m_done = 1; end
            end
            default: ;
        endcase
    endfunction

    // Byte source and per-run logs
    logic [7:0] src[$];
    int   src_idx, rel;
    int   ready_log[$], done_log[$];
    logic hist [0:511];

    task automatic step(input bit p, input bit s, input bit m, input bit v);
        bit took;
        play = p; stop = s; motor = m; byte_valid = v;
        if (src_idx < src.size()) begin
            byte_data = src[src_idx];
            byte_last = (src_idx == src.size() - 1);
        end else begin
            byte_data = 8'($urandom);
            byte_last = 1'($urandom);
        end
        ce = ce_rand ? ($urandom_range(0, 9) != 0) : 1'b1;
        @(negedge clock);
        took = m_ready();
        if (chk_en) begin
            chk("ear", ear, m_ear);
            chk("busy", busy, m_busy());
            chk("underrun", underrun, m_underrun);
            chk("done", done, m_done);
            chk("byte_ready", byte_ready, took);
        end
        if (rel < 512) hist[rel] = ear;
        if (byte_ready) ready_log.push_back(rel);
        if (done) done_log.push_back(rel);
        if (reset) model_reset();
        else model_edge();
        if (took) src_idx++;
        rel++;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1;
        repeat (n) step(0, 0, 1, 0);
        reset = 0;
    endtask

    // Play one file; valid/motor are low in [vlo,vhi) / [mlo,mhi) unless rnd.
    task automatic run_file(input int vlo, input int vhi, input int mlo, input int mhi, input bit rnd);
        int guard;
        bit p, s, m, v;
        src_idx = 0; rel = 0; ready_log.delete(); done_log.delete();
        step(1, 0, 1, 1);
        guard = 0;
        while (!(m_mode == M_IDLE || (m_mode == M_DONE && !m_done)) && guard < GUARD) begin
            if (rnd) begin
                p = ($urandom_range(0, 59) == 0);
                s = ($urandom_range(0, 499) == 0);
                m = ($urandom_range(0, 9) != 0);
                v = ($urandom_range(0, 9) < 7);
            end else begin
                p = 0; s = 0;
                v = !(rel >= vlo && rel < vhi);
                m = !(rel >= mlo && rel < mhi);
            end
            step(p, s, m, v);
            guard++;
        end
        chki("file_bound", (guard >= GUARD) ? 1 : 0, 0);
    endtask

    function automatic int ones(input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) n += (hist[i] === 1'b1) ? 1 : 0;
        return n;
    endfunction

    typedef struct {
        bit play, stop, valid;
        bit ear, busy, rdy, done;
    } vec_t;

    vec_t tbl[$];
    logic [59:0] pat;

    initial begin
        // leader 1100 x3, then A5 = 1 0 1 0 0 1 0 1
        pat = 60'b110011001100_11110000_1100_11110000_1100_1100_11110000_1100_11110000;
        tbl.push_back('{1, 0, 1, 0, 0, 0, 0});
        for (int i = 0; i < 60; i++) tbl.push_back('{0, 0, 1, pat[59 - i], 1, 0, 0});
        tbl.push_back('{1, 1, 1, 0, 1, 0, 0});   // fetch cycle: stop beats play and fetch
        tbl.push_back('{1, 1, 1, 0, 0, 0, 0});   // idle, play+stop together: stay idle
        tbl.push_back('{0, 0, 1, 0, 0, 0, 0});

        reset = 1; play = 0; stop = 0; motor = 1; ce = 1;
        byte_valid = 0; byte_data = 0; byte_last = 0;
        chk_en = 0; ce_rand = 0; src_idx = 0; rel = 0;
        model_reset();
        step(0, 0, 1, 0);
        chk_en = 1;
        do_reset(2);

        // Table: leader + sync waveform, then stop during DATA
        for (int i = 0; i < tbl.size(); i++) begin
            play = tbl[i].play; stop = tbl[i].stop; byte_valid = tbl[i].valid;
            motor = 1; ce = 1;
            @(negedge clock);
            chk($sformatf("tbl%0d_ear", i), ear, tbl[i].ear);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
            chk($sformatf("tbl%0d_ready", i), byte_ready, tbl[i].rdy);
            chk($sformatf("tbl%0d_done", i), done, tbl[i].done);
            @(posedge clock);
            #1;
        end
        do_reset(1);

        // Two bytes, source always valid
        src = '{8'h80, 8'h01};
        run_file(-1, -1, -1, -1, 0);
        chki("s2_ready_count", ready_log.size(), 2);
        chki("s2_ready0", ready_log.size() > 0 ? ready_log[0] : -1, 61);
        chki("s2_ready1", ready_log.size() > 1 ? ready_log[1] : -1, 98);
        chki("s2_done_cycle", done_log.size() == 1 ? done_log[0] : -1, 140);
        chki("s2_trail_low", ones(135, 139), 0);
        chk("s2_busy_end", busy, 1'b0);

        // Underrun at the second fetch
        src = '{8'h12, 8'h34};
        run_file(102, 112, -1, -1, 0);
        chki("s3_ready0", ready_log.size() > 0 ? ready_log[0] : -1, 61);
        chki("s3_ready1", ready_log.size() > 1 ? ready_log[1] : -1, 112);
        chki("s3_stall_low", ones(102, 112), 0);
        chk("s3_resume_hi", hist[113], 1'b1);
        chk("s3_resume_lo", hist[115], 1'b0);
        chk("s3_underrun", underrun, 1'b1);

        // play in DONE restarts and clears underrun; reset mid-leader
        step(1, 0, 1, 0);
        chk("restart_busy", busy, 1'b1);
        chk("restart_underrun", underrun, 1'b0);
        chk("restart_ear", ear, 1'b1);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        do_reset(1);
        chk("rst_ear", ear, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ready", byte_ready, 1'b0);
        chk("rst_underrun", underrun, 1'b0);

        // Motor freeze inside the high phase of a '1' cell
        src = '{8'hFF};
        run_file(-1, -1, 63, 70, 0);
        chki("s4_high_run", ones(62, 72), 11);
        chki("s4_low_run", ones(73, 76), 0);
        chk("s4_next_cell", hist[77], 1'b1);

        // Randomized files against the model
        ce_rand = 1;
        for (int f = 0; f < 40; f++) begin
            int n;
            n = $urandom_range(1, 3);
            src.delete();
            for (int b = 0; b < n; b++) src.push_back(8'($urandom));
            step(0, 1, 1, 0);
            run_file(-1, -1, -1, -1, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lynx_tape_player.md
Name: lynx_tape_player

Overview:
- Upstream of the machine top: converts a stream of tape-file bytes into the Lynx cassette waveform that drives the top-level `ear` input.
- The byte source is the tape buffer reader: it fetches bytes from the downloaded tape image and presents them on a valid/ready interface.
- Each byte becomes a leader, a sync byte and MSB-first bit cells.
- Playback is gated by the cassette motor bit, so the ROM loader sees a real-deck timing profile.

Parameters:
- ZERO_HALF, 1000, half-period of a '0' bit cell in ce ticks (1..65535).
- ONE_HALF, 2000, half-period of a '1' bit cell in ce ticks (1..65535).
- LEADER_BITS, 768, number of '0' cells emitted before the sync byte (1..65535).
- SYNC_BYTE, 8'hA5, byte emitted MSB-first after the leader.
- TRAIL_TICKS, 8000, ear-low ticks after the last data cell before DONE.
- MOTOR_GATE, 1, 1 = motor=0 freezes playback; 0 = motor ignored.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ce  in  1  timing tick enable; all timers advance only when ce=1
- play  in  1  one-cycle start pulse
- stop  in  1  one-cycle abort pulse
- motor  in  1  cassette motor bit from port 80h
- byte_valid  in  1  byte_data and byte_last are valid
- byte_data  in  8  next tape byte
- byte_last  in  1  byte_data is the final byte of the file
- byte_ready  out  1  single-cycle accept strobe
- ear  out  1  cassette waveform
- busy  out  1  high in any state other than IDLE and DONE
- underrun  out  1  sticky: source failed to supply a byte in time
- done  out  1  one-cycle pulse on entering DONE

Behaviour:
- Reset, synchronous: state=IDLE; ear=0, byte_ready=0, busy=0, underrun=0, done=0; all counters 0.
- Bit cell: ear=1 for H ticks, then ear=0 for H ticks. H=ONE_HALF for '1', H=ZERO_HALF for '0'. A cell lasts exactly 2H ce ticks.
- The next cell's high phase starts on the tick after the previous cell's last low tick. There is no gap between cells.
- States: IDLE, LEADER, SYNC, DATA, STALL, TRAIL, DONE.
- IDLE:
  - play -> LEADER; clear underrun.
  - play is ignored while busy.
- LEADER: emit LEADER_BITS '0' cells, then -> SYNC.
- SYNC: emit SYNC_BYTE MSB-first, then -> DATA with the first byte fetched.
- Fetch rule:
  - A byte is taken on a cycle with byte_valid=1 and byte_ready=1. byte_ready is asserted only on that cycle.
  - Fetch happens at the boundary where the previous byte's bit 0 (or the sync byte's bit 0) ends.
  - The accepted byte_data and byte_last are latched into the shift register; its bit 7 starts on the next ce tick.
- DATA:
  - Shift MSB-first.
  - After bit 0 of a byte latched with byte_last=1 -> TRAIL, with no fetch.
  - Otherwise fetch. If byte_valid=0 at the boundary -> STALL and set underrun.
- STALL:
  - ear=0.
  - Each clock with byte_valid=1 accepts the byte and returns to DATA.
  - The timing gap is not compensated.
- TRAIL: ear=0 for TRAIL_TICKS ce ticks, then -> DONE.
- DONE:
  - done pulses for 1 clock.
  - Stay in DONE until play (-> LEADER) or reset.
- Motor gate: with MOTOR_GATE=1 and motor=0, the state, counters and ear level freeze. Fetch strobes are also withheld.
- Resuming motor continues the current cell with its remaining ticks.
- stop:
  - From any state -> IDLE next clock; ear=0, byte_ready=0, no done.
  - stop wins over play and over fetch in the same cycle.
- play and stop together in IDLE: stay in IDLE.
- Counters:
  - Half-period counter is 16 bit and counts down from H-1.
  - Leader counter is 16 bit.
  - Bit index is 3 bit; the byte ends when the index wraps 0 -> 7.
- Latency: play accepted -> ear=1 on the next ce tick (first leader cell).

Decomposition:
- Package lynx_tape_pkg:
  - State enum type (7 states).
  - Default half-period, leader and trail constants.
  - Counter width constant (16).
- Sub-module lynx_tape_cell:
  - Inputs: clock, reset, ce, run (=motor gate), start, bit, plus half-period values.
  - Outputs: ear level, cell_end pulse on the last low tick.
  - Owns the half-period counter.
- The parent owns the FSM, leader count, shift register, fetch handshake and flags.

Test Plan (ZERO_HALF=2, ONE_HALF=4, LEADER_BITS=3, TRAIL_TICKS=5, ce=1 always, MOTOR_GATE=1, motor=1 unless stated):
- Reset held 3 cycles, then play -> ear pattern 1100 ×3 (leader). Then A5 (10100101) gives cells 11110000,1100,11110000,1100,1100,11110000,1100,11110000.
- Bytes 0x80 then 0x01 (last), source always valid -> byte_ready pulses exactly twice, each on the cycle after the preceding bit-0 cell ends. Followed by 5 low ticks, done=1 for 1 cycle, busy=0.
- Source deasserts byte_valid for 10 cycles at the 2nd fetch -> underrun=1, ear=0 throughout. On valid, the byte is accepted and output resumes with a cell of that byte's bit 7.
- motor=0 for 7 cycles mid high-phase of a '1' cell -> ear held at 1 and no counter progress. After motor=1, the remaining high ticks complete and the total cell is 8 active ticks.
- stop during DATA and play in the same cycle -> IDLE, ear=0, busy=0, no done. A later play restarts from the leader and clears underrun.
- Synchronous reset asserted mid-LEADER -> next cycle: all outputs 0 and state IDLE. play during DONE -> restarts LEADER.
